ecall_sequencer: RTL and testbench



---
 rtl/ecall_sequencer_if.sv | 26 ++
 rtl/ecall_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ecall_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecall_sequencer_if.sv
// rtl/ecall_sequencer_if.sv - core-side signal bundle for the ECALL service sequencer
interface ecall_sequencer_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] a7_val;
    logic [31:0] a0_val;
    logic [7:0]  switch_in;
    logic        confirm_btn;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] reg_map_tube;
    logic [31:0] reg_map_led;
    logic        halted;

    modport slave (
        input  opcode, funct3, a7_val, a0_val, switch_in, confirm_btn,
        output stall, wb_en, wb_addr, wb_data, reg_map_tube, reg_map_led, halted
    );

    modport master (
        output opcode, funct3, a7_val, a0_val, switch_in, confirm_btn,
        input  stall, wb_en, wb_addr, wb_data, reg_map_tube, reg_map_led, halted
    );
endinterface

// File: rtl/ecall_sequencer.sv
// rtl/ecall_sequencer.sv - multi-cycle ECALL service controller (tube, LEDs, switches, halt)
module ecall_sequencer #(
    parameter int DB_CYCLES = 230000,
    parameter int SVC_PRINT = 1,
    parameter int SVC_LED   = 2,
    parameter int SVC_READ  = 5,
    parameter int SVC_EXIT  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    ecall_sequencer_if.slave  bus
);
    localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_WRITEBACK,
        S_RELEASE,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   svc_q;
    logic [31:0]   arg_q;
    logic [7:0]    cap_q;
    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          sync1_q, sync2_q;
    logic [31:0]   tube_q;
    logic [31:0]   led_q;

    logic ecall_hit;
    logic btn_s;
    logic press_done;
    logic release_done;

    assign ecall_hit    = (bus.opcode == 7'b1110011) && (bus.funct3 == 3'b000);
    assign btn_s        = sync2_q;
    // A press only counts once the sequencer has seen the button up inside this service.
    assign press_done   = armed_q && btn_s && (cnt_q == DB_LAST);
    assign release_done = !btn_s && (cnt_q == DB_LAST);

    // Two-flop synchronizer for the asynchronous confirm button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.confirm_btn;
            sync2_q <= sync1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ecall_hit) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (svc_q == 32'(SVC_READ))      state_d = S_WAIT_PRESS;
                else if (svc_q == 32'(SVC_EXIT)) state_d = S_HALT;
                else                             state_d = S_RELEASE;
            end
            S_WAIT_PRESS: begin
                if (press_done) state_d = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (release_done) state_d = S_WRITEBACK;
            end
            S_WRITEBACK: state_d = S_RELEASE;
            // The ECALL is still on the bus here; going straight to IDLE without
            // looking at it lets the PC step past it first.
            S_RELEASE:   state_d = S_IDLE;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs: stall covers the detect cycle and every busy state.
    always_comb begin
        bus.stall  = 1'b0;
        bus.wb_en  = 1'b0;
        bus.halted = 1'b0;
        case (state_q)
            S_IDLE:      bus.stall = ecall_hit;
            S_RELEASE:   bus.stall = 1'b0;
            S_WRITEBACK: begin
                bus.stall = 1'b1;
                bus.wb_en = 1'b1;
            end
            S_HALT: begin
                bus.stall  = 1'b1;
                bus.halted = 1'b1;
            end
            default:     bus.stall = 1'b1;
        endcase
    end

    assign bus.wb_addr      = 5'd10;
    assign bus.wb_data      = {24'b0, cap_q};
    assign bus.reg_map_tube = tube_q;
    assign bus.reg_map_led  = led_q;

    // Service datapath: argument latch, output registers, debounce counter and capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            svc_q   <= '0;
            arg_q   <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            tube_q  <= '0;
            led_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ecall_hit) begin
                        svc_q <= bus.a7_val;
                        arg_q <= bus.a0_val;
                    end
                end
                S_EXEC: begin
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                    if (svc_q == 32'(SVC_PRINT)) tube_q <= arg_q;
                    if (svc_q == 32'(SVC_LED))   led_q  <= arg_q;
                end
                S_WAIT_PRESS: begin
                    if (!armed_q) begin
                        cnt_q <= '0;
                        if (!btn_s) armed_q <= 1'b1;
                    end else if (!btn_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        cap_q <= bus.switch_in;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (btn_s || (cnt_q == DB_LAST)) cnt_q <= '0;
                    else                             cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecall_sequencer.sv
// tb/tb_ecall_sequencer.sv - directed self-checking bench for ecall_sequencer
module tb_ecall_sequencer;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_NOP    = 7'b0010011;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   tot_cnt;

    ecall_sequencer_if bus();

    ecall_sequencer #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = OP_NOP; bus.funct3 = 3'b000;
        bus.a7_val = 32'd0; bus.a0_val = 32'd0;
        bus.switch_in = 8'h00; bus.confirm_btn = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.wb_en !== 1'b0) $display("FAIL reset_wb_en got %0b want 0", bus.wb_en); else pass_cnt++;
        tot_cnt++; if (bus.wb_data !== 32'd0) $display("FAIL reset_wb_data got %h want 0", bus.wb_data); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_tube !== 32'd0) $display("FAIL reset_tube got %h want 0", bus.reg_map_tube); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_led !== 32'd0) $display("FAIL reset_led got %h want 0", bus.reg_map_led); else pass_cnt++;
        tot_cnt++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got %0b want 0", bus.halted); else pass_cnt++;
        tot_cnt++; if (bus.wb_addr !== 5'd10) $display("FAIL wb_addr got %0d want 10", bus.wb_addr); else pass_cnt++;
    endtask

    task automatic test_print();
        bus.a7_val = 32'd1; bus.a0_val = 32'h12345678; bus.opcode = OP_SYSTEM;
        #1;
        tot_cnt++; if (bus.stall !== 1'b1) $display("FAIL print_detect_stall got %0b want 1", bus.stall); else pass_cnt++;
        tick();
        bus.a0_val = 32'hDEADBEEF;
        #1;
        tot_cnt++; if (bus.stall !== 1'b1) $display("FAIL print_exec_stall got %0b want 1", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.wb_en !== 1'b0) $display("FAIL print_exec_wb_en got %0b want 0", bus.wb_en); else pass_cnt++;
        tick();
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL print_release_stall got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_tube !== 32'h12345678) $display("FAIL print_tube got %h want 12345678", bus.reg_map_tube); else pass_cnt++;
        bus.opcode = OP_NOP;
        tick();
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL print_idle_stall got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.wb_en !== 1'b0) $display("FAIL print_idle_wb_en got %0b want 0", bus.wb_en); else pass_cnt++;
    endtask

    task automatic test_read();
        int bad;
        int pulses;
        int released;
        bus.a7_val = 32'd5; bus.a0_val = 32'd0; bus.switch_in = 8'hA5;
        bus.confirm_btn = 1'b0; bus.opcode = OP_SYSTEM;
        tick(); tick(); tick();
        bus.confirm_btn = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.stall !== 1'b1 || bus.wb_en !== 1'b0) bad++;
        end
        tot_cnt++; if (bad != 0) $display("FAIL read_press_hold bad_cycles %0d want 0", bad); else pass_cnt++;
        bus.confirm_btn = 1'b0;
        pulses = 0; released = 0;
        for (int i = 0; i < 20 && released == 0; i++) begin
            tick();
            if (bus.wb_en === 1'b1) begin
                pulses++;
                tot_cnt++; if (bus.wb_data !== 32'h000000A5) $display("FAIL read_wb_data got %h want 000000a5", bus.wb_data); else pass_cnt++;
                tot_cnt++; if (bus.wb_addr !== 5'd10) $display("FAIL read_wb_addr got %0d want 10", bus.wb_addr); else pass_cnt++;
                tot_cnt++; if (bus.stall !== 1'b1) $display("FAIL read_wb_stall got %0b want 1", bus.stall); else pass_cnt++;
                tick();
                tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL read_release_stall got %0b want 0", bus.stall); else pass_cnt++;
                bus.opcode = OP_NOP;
                released = 1;
            end
        end
        tot_cnt++; if (pulses != 1) $display("FAIL read_wb_pulses got %0d want 1", pulses); else pass_cnt++;
        tick();
    endtask

    task automatic test_debounce_arming();
        int pulses;
        int released;
        bus.a7_val = 32'd5; bus.switch_in = 8'h3C;
        bus.confirm_btn = 1'b1;
        tick(); tick(); tick();
        bus.opcode = OP_SYSTEM;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.wb_en === 1'b1) pulses++;
        end
        bus.confirm_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.wb_en === 1'b1) pulses++;
        end
        tot_cnt++; if (pulses != 0) $display("FAIL arm_preheld_pulses got %0d want 0", pulses); else pass_cnt++;
        bus.confirm_btn = 1'b1;
        tick(); tick();
        bus.confirm_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.wb_en === 1'b1) pulses++;
        end
        tot_cnt++; if (pulses != 0) $display("FAIL glitch_pulses got %0d want 0", pulses); else pass_cnt++;
        tot_cnt++; if (bus.stall !== 1'b1) $display("FAIL glitch_stall got %0b want 1", bus.stall); else pass_cnt++;
        bus.confirm_btn = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        bus.confirm_btn = 1'b0;
        released = 0;
        for (int i = 0; i < 20 && released == 0; i++) begin
            tick();
            if (bus.wb_en === 1'b1) begin
                pulses++;
                tot_cnt++; if (bus.wb_data !== 32'h0000003C) $display("FAIL arm_wb_data got %h want 0000003c", bus.wb_data); else pass_cnt++;
                tick();
                bus.opcode = OP_NOP;
                released = 1;
            end
        end
        tot_cnt++; if (pulses != 1) $display("FAIL arm_final_pulses got %0d want 1", pulses); else pass_cnt++;
        tick();
    endtask

    task automatic test_exit();
        int bad;
        bus.a7_val = 32'd10; bus.opcode = OP_SYSTEM;
        tick(); tick();
        bus.opcode = OP_NOP;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.stall !== 1'b1 || bus.halted !== 1'b1) bad++;
            tick();
        end
        tot_cnt++; if (bad != 0) $display("FAIL exit_halt_hold bad_cycles %0d want 0", bad); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL exit_reset_stall got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.halted !== 1'b0) $display("FAIL exit_reset_halted got %0b want 0", bus.halted); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_tube !== 32'd0) $display("FAIL exit_reset_tube got %h want 0", bus.reg_map_tube); else pass_cnt++;
        tot_cnt++; if (bus.wb_data !== 32'd0) $display("FAIL exit_reset_wb_data got %h want 0", bus.wb_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.a7_val = 32'd7; bus.a0_val = 32'h00000099; bus.opcode = OP_SYSTEM;
        tick();
        tick();
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL b2b_first_release got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_tube !== 32'd0 || bus.reg_map_led !== 32'd0)
            $display("FAIL b2b_noop_outputs got tube %h led %h want 0 0", bus.reg_map_tube, bus.reg_map_led); else pass_cnt++;
        bus.a7_val = 32'd2; bus.a0_val = 32'h000000FF;
        tick();
        tot_cnt++; if (bus.stall !== 1'b1) $display("FAIL b2b_second_detect got %0b want 1", bus.stall); else pass_cnt++;
        tick();
        tot_cnt++; if (bus.stall !== 1'b1) $display("FAIL b2b_second_exec got %0b want 1", bus.stall); else pass_cnt++;
        tick();
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL b2b_second_release got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_led !== 32'h000000FF) $display("FAIL b2b_led got %h want 000000ff", bus.reg_map_led); else pass_cnt++;
        tot_cnt++; if (bus.reg_map_tube !== 32'd0) $display("FAIL b2b_tube got %h want 0", bus.reg_map_tube); else pass_cnt++;
        bus.opcode = OP_NOP;
        tick();
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL b2b_idle got %0b want 0", bus.stall); else pass_cnt++;
    endtask

    task automatic test_reset_wait_release();
        int pulses;
        int bad;
        bus.a7_val = 32'd5; bus.switch_in = 8'h77; bus.confirm_btn = 1'b0; bus.opcode = OP_SYSTEM;
        tick(); tick(); tick();
        bus.confirm_btn = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        bus.confirm_btn = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.opcode = OP_NOP;
        #1;
        tot_cnt++; if (bus.stall !== 1'b0) $display("FAIL rwr_stall got %0b want 0", bus.stall); else pass_cnt++;
        tot_cnt++; if (bus.wb_data !== 32'd0) $display("FAIL rwr_wb_data got %h want 0", bus.wb_data); else pass_cnt++;
        pulses = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.wb_en === 1'b1) pulses++;
            if (bus.stall !== 1'b0) bad++;
        end
        tot_cnt++; if (pulses != 0) $display("FAIL rwr_wb_pulses got %0d want 0", pulses); else pass_cnt++;
        tot_cnt++; if (bad != 0) $display("FAIL rwr_idle_stall bad_cycles %0d want 0", bad); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        tot_cnt  = 0;
        test_reset();
        test_print();
        test_read();
        test_debounce_arming();
        test_exit();
        test_back_to_back();
        test_reset_wait_release();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
